serial_frame_tx: RTL and testbench

Parallel-in, serial-out framed transmitter. It accepts a WIDTH-bit word on a valid/ready handshake and shifts it onto a single line as start bit, data bits (LSB- or MSB-first), optional even parity and a stop bit. Each bit is held for DIV clock cycles. It is the transmit end for the team's serial-in shift-register receive path and sits between a parallel producer and the serial link.

---
 rtl/serial_frame_pkg.sv | 22 ++
 rtl/tx_bit_timer.sv | 30 +++
 rtl/serial_frame_tx.sv | 146 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial framing link: state encoding, line levels
// and the parity helper used by both the transmit and receive sides.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Even parity: the bit that makes the total count of ones even.
    // Callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each period.
// A restart pulse realigns the period to the following cycle.
module tx_bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    assign tick = (cnt_r == LAST);

    // Period counter, wrapping on tick and cleared on every state change.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_r <= '0;
        end else if (restart || tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits in either order,
// optional even parity and a stop bit, each held for DIV clock cycles.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    input  logic             msb_first,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_e        state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [BW-1:0]    bcnt_r, bcnt_s;
    logic             msb_r, msb_s;
    logic             par_r, par_s;
    logic             sout_r, sout_s;
    logic             done_r, done_s;
    logic             ready_r, busy_r;
    logic             restart_s, tick_s;

    tx_bit_timer #(.DIV(DIV)) u_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Next-state, datapath and line-level decode for the frame FSM.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        bcnt_s  = bcnt_r;
        msb_s   = msb_r;
        par_s   = par_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    state_s = ST_START;
                    shreg_s = d;
                    msb_s   = msb_first;
                    par_s   = even_parity(64'(d));
                    bcnt_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shreg_s = msb_r ? {shreg_r[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_r[WIDTH-1:1]};
                    bcnt_s  = bcnt_r + BW'(1'b1);
                    if (bcnt_r == LAST_BIT) begin
                        state_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        restart_s = (state_s != state_r);

        // The line level is taken from the next state so sout can be registered
        // and still line up with the state it belongs to.
        case (state_s)
            ST_IDLE:   sout_s = LINE_IDLE;
            ST_START:  sout_s = LINE_START;
            ST_DATA:   sout_s = msb_s ? shreg_s[WIDTH-1] : shreg_s[0];
            ST_PARITY: sout_s = par_s;
            ST_STOP:   sout_s = LINE_IDLE;
            default:   sout_s = LINE_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            shreg_r <= '0;
            bcnt_r  <= '0;
            msb_r   <= 1'b0;
            par_r   <= 1'b0;
            sout_r  <= LINE_IDLE;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            bcnt_r  <= bcnt_s;
            msb_r   <= msb_s;
            par_r   <= par_s;
            sout_r  <= sout_s;
            done_r  <= done_s;
            ready_r <= (state_s == ST_IDLE);
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign sout  = sout_r;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default 4-bit/DIV=4/parity instance plus
// an 8-bit/DIV=1/no-parity instance, outputs sampled on the falling edge.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic       valid;
    logic       msb_first;
    logic [3:0] d;
    logic       ready, sout, busy, done;

    logic       valid2;
    logic       msb2;
    logic [7:0] d2;
    logic       ready2, sout2, busy2, done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(4), .DIV(4), .PARITY_EN(1)) dut (
        .clk(clk), .clr(clr), .d(d), .valid(valid), .msb_first(msb_first),
        .ready(ready), .sout(sout), .busy(busy), .done(done)
    );

    serial_frame_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(0)) dut8 (
        .clk(clk), .clr(clr), .d(d2), .valid(valid2), .msb_first(msb2),
        .ready(ready2), .sout(sout2), .busy(busy2), .done(done2)
    );

    // Present a word at a falling edge; it is accepted on the following rising edge.
    task automatic send(input logic [3:0] w, input logic m, input logic hold);
        @(negedge clk);
        d = w;
        msb_first = m;
        valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({ready, sout, busy, done} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got rdy/sout/busy/done=%b expected 1100", i, {ready, sout, busy, done});
            end
        end
        clr = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, sout, busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: got rdy/sout/busy=%b expected 110", {ready, sout, busy});
        end
    endtask

    task automatic test_lsb();
        logic [6:0] e = 7'b1110110;
        send(4'b1011, 1'b0, 1'b0);
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            checks++;
            if (k <= 28) begin
                if (sout !== e[(k-1)/4] || done !== 1'b0) begin
                    errors++;
                    $display("FAIL lsb_frame cyc %0d: got sout=%b done=%b expected sout=%b done=0", k, sout, done, e[(k-1)/4]);
                end
            end else if ({done, ready, sout} !== 3'b111) begin
                errors++;
                $display("FAIL lsb_done cyc %0d: got done/rdy/sout=%b expected 111", k, {done, ready, sout});
            end
        end
    endtask

    task automatic test_msb();
        logic [6:0] e = 7'b1001100;
        int busy_cnt = 0;
        send(4'b0110, 1'b1, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (k <= 28) begin
                checks++;
                if (sout !== e[(k-1)/4]) begin
                    errors++;
                    $display("FAIL msb_frame cyc %0d: got sout=%b expected %b", k, sout, e[(k-1)/4]);
                end
            end
        end
        checks++;
        if (busy_cnt != 28) begin
            errors++;
            $display("FAIL msb_busy_len: got %0d cycles expected 28", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e1 = 7'b1011110;
        logic [6:0] e2 = 7'b1000000;
        logic       exp_s;
        send(4'hF, 1'b0, 1'b1);
        d = 4'h0;
        for (int k = 1; k <= 58; k++) begin
            @(negedge clk);
            if (k == 30) valid = 1'b0;
            if (k <= 28)      exp_s = e1[(k-1)/4];
            else if (k == 29) exp_s = 1'b1;
            else if (k <= 57) exp_s = e2[(k-30)/4];
            else              exp_s = 1'b1;
            checks++;
            if (sout !== exp_s || done !== (k == 29 || k == 58)) begin
                errors++;
                $display("FAIL b2b_frame cyc %0d: got sout=%b done=%b expected sout=%b done=%b", k, sout, done, exp_s, (k == 29 || k == 58));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] e  = 7'b1110110;
        logic [6:0] e2 = 7'b1000110;
        int done_cnt = 0;
        send(4'b1011, 1'b0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (sout !== e[(k-1)/4]) begin
                errors++;
                $display("FAIL abort_prefix cyc %0d: got sout=%b expected %b", k, sout, e[(k-1)/4]);
            end
        end
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({sout, busy, ready, done} !== 4'b1010) begin
            errors++;
            $display("FAIL abort_outputs: got sout/busy/rdy/done=%b expected 1010", {sout, busy, ready, done});
        end
        clr = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1 || sout !== 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d cycles with done or low line expected 0", done_cnt);
        end
        send(4'b0011, 1'b0, 1'b0);
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            checks++;
            if (k <= 28) begin
                if (sout !== e2[(k-1)/4]) begin
                    errors++;
                    $display("FAIL after_abort cyc %0d: got sout=%b expected %b", k, sout, e2[(k-1)/4]);
                end
            end else if (done !== 1'b1) begin
                errors++;
                $display("FAIL after_abort_done: got %b expected 1", done);
            end
        end
    endtask

    task automatic test_sweep8();
        logic [9:0] e = 10'b1101001010;
        @(negedge clk);
        d2 = 8'hA5;
        msb2 = 1'b0;
        valid2 = 1'b1;
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            checks++;
            if (k <= 10) begin
                if (sout2 !== e[k-1] || done2 !== 1'b0) begin
                    errors++;
                    $display("FAIL w8_frame cyc %0d: got sout=%b done=%b expected sout=%b done=0", k, sout2, done2, e[k-1]);
                end
            end else if ({done2, ready2, sout2} !== 3'b111) begin
                errors++;
                $display("FAIL w8_done: got done/rdy/sout=%b expected 111", {done2, ready2, sout2});
            end
        end
    endtask

    initial begin
        clr = 1'b0;
        valid = 1'b1;
        msb_first = 1'b0;
        d = 4'b1011;
        valid2 = 1'b0;
        msb2 = 1'b0;
        d2 = 8'h00;
        test_reset();
        test_lsb();
        repeat (3) @(negedge clk);
        test_msb();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_mid_reset();
        repeat (3) @(negedge clk);
        test_sweep8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
